smi_iq_frame_tx: RTL

//  Transmit-side framer for the SMI read path (FPGA -> Pi). Pulls 32-bit IQ words from the RX FIFO,

---
 rtl/smi_pkg.sv | 28 ++
 rtl/smi_strobe_sync.sv | 22 ++
 rtl/smi_iq_frame_tx.sv | 129 ++++++++++++
 3 files changed

// File: rtl/smi_pkg.sv
// smi_pkg: shared byte indices, FSM encoding, sync constants and frame helpers for the SMI IQ framer.
package smi_pkg;

    localparam logic [1:0] B0 = 2'd0;
    localparam logic [1:0] B1 = 2'd1;
    localparam logic [1:0] B2 = 2'd2;
    localparam logic [1:0] B3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [1:0]  SYNC_HI    = 2'b10;
    localparam logic [1:0]  SYNC_LO    = 2'b01;
    localparam logic [31:0] IDLE_FRAME = 32'hA000_0000;

    // Frame register layout is b0..b3 from MSB down; only b0 has bit7 set so the Pi can resync.
    function automatic logic [31:0] pack_frame(input logic [12:0] i, input logic [12:0] q, input logic flag);
        return {1'b1, flag, 1'b0, i[12:8], 1'b0, i[7:1], 1'b0, i[0], q[12:7], 1'b0, q[6:0]};
    endfunction

    function automatic logic word_ok(input logic [31:0] w);
        return w[31:30] == SYNC_HI && w[15:14] == SYNC_LO;
    endfunction

endpackage

// File: rtl/smi_strobe_sync.sv
// smi_strobe_sync: normalises SOE to asserted-high, double-syncs it into i_sys_clk and
// pulses adv for one cycle at the end of each strobe.
module smi_strobe_sync #(
    parameter bit SOE_ACTIVE_HIGH = 1'b0
) (
    input  logic i_sys_clk,
    input  logic i_rst_b,
    input  logic soe,
    output logic adv
);

    logic [2:0] sh;

    always_ff @(posedge i_sys_clk or negedge i_rst_b)
        if (!i_rst_b)
            sh <= '0;
        else
            sh <= {sh[1:0], soe ^ !SOE_ACTIVE_HIGH};

    assign adv = sh[2] & ~sh[1];

endmodule

// File: rtl/smi_iq_frame_tx.sv
// smi_iq_frame_tx: frames 32-bit RX FIFO IQ words into 4 SOF-tagged bytes for the SMI read path.
// Optional SMI_FRAMER_TEST_PATTERN_EN adds i_test_mode, which replaces FIFO data with a 13-bit ramp.
module smi_iq_frame_tx
    import smi_pkg::*;
#(
    parameter bit SOE_ACTIVE_HIGH = 1'b0,
    parameter int CNT_W           = 16
) (
    input  logic             i_sys_clk,
    input  logic             i_rst_b,
    input  logic             i_enable,
    input  logic             i_rx_fifo_empty,
    output logic             o_rx_fifo_pull,
    input  logic [31:0]      i_rx_fifo_pulled_data,
    input  logic             i_smi_soe_se,
    output logic [7:0]       o_smi_data_out,
    output logic             o_smi_read_req,
    input  logic             i_cnt_clear,
`ifdef SMI_FRAMER_TEST_PATTERN_EN
    input  logic             i_test_mode,
`endif
    output logic [CNT_W-1:0] o_underrun_cnt,
    output logic [CNT_W-1:0] o_malformed_cnt,
    output logic [1:0]       o_state
);

    state_t      state;
    logic [1:0]  byte_ix;
    logic [31:0] frame, nxt_word, fifo_frame, ld_frame;
    logic [7:0]  cur;
    logic        nxt_vld, cap, adv, tm, in_flight, boundary, load, consume, under, bad;
    logic        unused_lsb;

    smi_strobe_sync #(.SOE_ACTIVE_HIGH(SOE_ACTIVE_HIGH)) u_sync (
        .i_sys_clk(i_sys_clk),
        .i_rst_b  (i_rst_b),
        .soe      (i_smi_soe_se),
        .adv      (adv)
    );

    assign fifo_frame = nxt_vld && word_ok(nxt_word) ?
                        pack_frame(nxt_word[29:17], nxt_word[13:1], nxt_word[16]) : IDLE_FRAME;
    assign unused_lsb = nxt_word[0];

`ifdef SMI_FRAMER_TEST_PATTERN_EN
    logic [12:0] ramp;
    assign tm       = i_test_mode;
    assign ld_frame = tm ? pack_frame(ramp, ~ramp, 1'b0) : fifo_frame;
    always_ff @(posedge i_sys_clk or negedge i_rst_b)
        if (!i_rst_b)
            ramp <= '0;
        else if (load && tm)
            ramp <= ramp + 13'd1;
`else
    assign tm       = 1'b0;
    assign ld_frame = fifo_frame;
`endif

    // The first load after enable waits for a word already on its way; with nothing coming it
    // starts on the idle frame. Only missed frame boundaries count as underruns.
    assign in_flight = o_rx_fifo_pull | cap | !i_rx_fifo_empty;
    assign boundary  = state == SEND && adv && byte_ix == B3 && i_enable;
    assign load      = boundary || (state == LOAD && (nxt_vld || tm || !in_flight));
    assign consume   = load && nxt_vld && !tm;
    assign under     = boundary && !nxt_vld && !tm;
    assign bad       = consume && !word_ok(nxt_word);

    assign o_smi_read_req = (state == SEND && byte_ix != B0) || nxt_vld;
    assign o_state        = state;

    always_comb
        case (byte_ix)
            B0:      cur = frame[31:24];
            B1:      cur = frame[23:16];
            B2:      cur = frame[15:8];
            default: cur = frame[7:0];
        endcase

    always_ff @(posedge i_sys_clk or negedge i_rst_b)
        if (!i_rst_b) begin
            o_rx_fifo_pull <= 1'b0;
            cap            <= 1'b0;
            nxt_vld        <= 1'b0;
            nxt_word       <= '0;
        end else begin
            o_rx_fifo_pull <= state != IDLE && !tm && !nxt_vld && !i_rx_fifo_empty && !o_rx_fifo_pull && !cap;
            cap            <= o_rx_fifo_pull;
            if (cap) begin
                nxt_word <= i_rx_fifo_pulled_data;
                nxt_vld  <= 1'b1;
            end else if (consume)
                nxt_vld <= 1'b0;
        end

    always_ff @(posedge i_sys_clk or negedge i_rst_b)
        if (!i_rst_b) begin
            state          <= IDLE;
            byte_ix        <= B0;
            frame          <= '0;
            o_smi_data_out <= 8'h00;
        end else begin
            o_smi_data_out <= cur;
            if (state == SEND && adv)
                byte_ix <= byte_ix + 2'd1;
            if (load)
                frame <= ld_frame;
            case (state)
                IDLE:    state <= i_enable ? LOAD : IDLE;
                LOAD:    state <= load ? SEND : LOAD;
                SEND:    state <= adv && byte_ix == B3 && !i_enable ? IDLE : SEND;
                default: state <= IDLE;
            endcase
        end

    always_ff @(posedge i_sys_clk or negedge i_rst_b)
        if (!i_rst_b) begin
            o_underrun_cnt  <= '0;
            o_malformed_cnt <= '0;
        end else if (i_cnt_clear) begin
            o_underrun_cnt  <= '0;
            o_malformed_cnt <= '0;
        end else begin
            if (under && !(&o_underrun_cnt))
                o_underrun_cnt <= o_underrun_cnt + 1'b1;
            if (bad && !(&o_malformed_cnt))
                o_malformed_cnt <= o_malformed_cnt + 1'b1;
        end

endmodule
